// File: rtl/mem_writeback_buffer.sv
// mem_writeback_buffer: circular FIFO of load results queued toward the register writeback arbiter.
module mem_writeback_buffer #(
  parameter int DATABITWIDTH    = 16,
  parameter int REGADDRBITWIDTH = 4,
  parameter int DEPTH           = 4,
  parameter int DEPTHADDRWIDTH  = 2
) (
  input  logic                      clk,
  input  logic                      async_rst_n,
  input  logic                      clk_en,
  input  logic                      LoadValid,
  output logic                      LoadReady,
  input  logic [DATABITWIDTH-1:0]   LoadData,
  input  logic [REGADDRBITWIDTH-1:0] LoadAddr,
  output logic                      MemWritebackACK,
  input  logic                      MemWritebackREQ,
  output logic [DATABITWIDTH-1:0]   MemWritebackDataOut,
  output logic [REGADDRBITWIDTH-1:0] MemWritebackAddrOut,
  output logic [DEPTHADDRWIDTH:0]   Occupancy,
  output logic                      DropError
);
  localparam logic [DEPTHADDRWIDTH:0] L_DEPTH = (DEPTHADDRWIDTH+1)'(DEPTH);
  logic [DATABITWIDTH-1:0]    r_data [DEPTH];
  logic [REGADDRBITWIDTH-1:0] r_addr [DEPTH];
  logic [DEPTHADDRWIDTH-1:0]  r_wr_ptr, r_rd_ptr;
  logic [DEPTHADDRWIDTH:0]    r_count, w_count_nxt;
  logic                       r_drop;
  logic                       w_full, w_empty, w_push, w_pop;
  // Handshakes decode from registered count only, so REQ never reaches LoadReady.
  assign w_full    = r_count == L_DEPTH;
  assign w_empty   = r_count == '0;
  assign w_push    = LoadValid & ~w_full & clk_en;
  assign w_pop     = MemWritebackREQ & ~w_empty & clk_en;
  always_comb begin
    w_count_nxt = r_count;
    w_count_nxt = (w_push & ~w_pop) ? r_count + 1'b1 :
                  (w_pop & ~w_push) ? r_count - 1'b1 : r_count;
  end
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      if (clk_en & LoadValid & w_full) r_drop <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= LoadData;
      r_addr[r_wr_ptr] <= LoadAddr;
    end
  end
  assign LoadReady           = ~w_full;
  assign MemWritebackACK     = ~w_empty;
  assign MemWritebackDataOut = w_empty ? '0 : r_data[r_rd_ptr];
  assign MemWritebackAddrOut = w_empty ? '0 : r_addr[r_rd_ptr];
  assign Occupancy           = r_count;
  assign DropError           = r_drop;
endmodule

// File: tb/tb_mem_writeback_buffer.sv
// tb_mem_writeback_buffer: directed checks of the writeback FIFO with default parameters.
module tb_mem_writeback_buffer;
  logic        clk = 1'b0;
  logic        async_rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        LoadValid = 1'b0;
  logic        LoadReady;
  logic [15:0] LoadData = '0;
  logic [3:0]  LoadAddr = '0;
  logic        MemWritebackACK;
  logic        MemWritebackREQ = 1'b0;
  logic [15:0] MemWritebackDataOut;
  logic [3:0]  MemWritebackAddrOut;
  logic [2:0]  Occupancy;
  logic        DropError;
  int errors = 0;
  int checks = 0;
  logic [15:0] q[$];
  logic [15:0] head;

  mem_writeback_buffer dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
    .LoadValid(LoadValid), .LoadReady(LoadReady), .LoadData(LoadData), .LoadAddr(LoadAddr),
    .MemWritebackACK(MemWritebackACK), .MemWritebackREQ(MemWritebackREQ),
    .MemWritebackDataOut(MemWritebackDataOut), .MemWritebackAddrOut(MemWritebackAddrOut),
    .Occupancy(Occupancy), .DropError(DropError)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2;
    chk("rst_ready", LoadReady, 1);
    chk("rst_ack", MemWritebackACK, 0);
    chk("rst_occ", Occupancy, 0);
    chk("rst_data", MemWritebackDataOut, 0);
    chk("rst_addr", MemWritebackAddrOut, 0);
    chk("rst_drop", DropError, 0);
    @(negedge clk);
    async_rst_n = 1'b1;
    clk_en = 1'b1;
    // single load with REQ held high
    LoadValid = 1'b1; LoadData = 16'h1234; LoadAddr = 4'd3; MemWritebackREQ = 1'b1;
    tick();
    LoadValid = 1'b0;
    chk("single_ack", MemWritebackACK, 1);
    chk("single_data", MemWritebackDataOut, 16'h1234);
    chk("single_addr", MemWritebackAddrOut, 3);
    chk("single_occ1", Occupancy, 1);
    tick();
    chk("single_occ0", Occupancy, 0);
    chk("single_ack0", MemWritebackACK, 0);
    chk("single_data0", MemWritebackDataOut, 0);
    // fill to full, then overflow
    MemWritebackREQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      LoadValid = 1'b1; LoadData = 16'hA0 + 16'(i); LoadAddr = 4'(i + 8);
      tick();
    end
    chk("full_occ", Occupancy, 4);
    chk("full_ready", LoadReady, 0);
    chk("full_drop0", DropError, 0);
    LoadData = 16'hEE;
    tick();
    LoadValid = 1'b0;
    chk("drop_set", DropError, 1);
    chk("drop_occ", Occupancy, 4);
    MemWritebackREQ = 1'b1;
    chk("drain_addr0", MemWritebackAddrOut, 8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_%0d", i), MemWritebackDataOut, 16'hA0 + i);
      tick();
    end
    chk("drain_occ", Occupancy, 0);
    chk("drop_sticky", DropError, 1);
    // full with same-cycle push and pop
    MemWritebackREQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      LoadValid = 1'b1; LoadData = 16'hB0 + 16'(i); LoadAddr = 4'(i);
      tick();
    end
    chk("full2_occ", Occupancy, 4);
    LoadData = 16'hC0; MemWritebackREQ = 1'b1;
    tick();
    chk("fullpop_occ", Occupancy, 3);
    chk("fullpop_ready", LoadReady, 1);
    chk("fullpop_head", MemWritebackDataOut, 16'hB1);
    MemWritebackREQ = 1'b0;
    tick();
    LoadValid = 1'b0;
    chk("fullpush_occ", Occupancy, 4);
    // drop to occupancy 2, then stream across pointer wrap
    MemWritebackREQ = 1'b1;
    tick(); tick();
    chk("stream_start_occ", Occupancy, 2);
    q = '{16'hB3, 16'hC0};
    LoadValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      LoadData = 16'hD0 + 16'(i);
      head = q.pop_front();
      q.push_back(LoadData);
      chk($sformatf("stream_head_%0d", i), MemWritebackDataOut, head);
      tick();
      chk($sformatf("stream_occ_%0d", i), Occupancy, 2);
    end
    chk("stream_tail", MemWritebackDataOut, 16'hD8);
    // clock enable low freezes everything
    clk_en = 1'b0; LoadData = 16'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frz_occ_%0d", i), Occupancy, 2);
      chk($sformatf("frz_head_%0d", i), MemWritebackDataOut, 16'hD8);
    end
    clk_en = 1'b1;
    tick();
    chk("resume_head", MemWritebackDataOut, 16'hD9);
    // async reset mid-stream
    #2 async_rst_n = 1'b0;
    #1;
    chk("mrst_ack", MemWritebackACK, 0);
    chk("mrst_occ", Occupancy, 0);
    chk("mrst_drop", DropError, 0);
    chk("mrst_ready", LoadReady, 1);
    chk("mrst_data", MemWritebackDataOut, 0);
    tick();
    chk("mrst_hold_occ", Occupancy, 0);
    @(negedge clk);
    async_rst_n = 1'b1;
    LoadValid = 1'b0; MemWritebackREQ = 1'b1;
    tick();
    chk("empty_req_occ", Occupancy, 0);
    chk("empty_req_ack", MemWritebackACK, 0);
    LoadValid = 1'b1; LoadData = 16'h55; LoadAddr = 4'd5; MemWritebackREQ = 1'b0;
    tick();
    LoadValid = 1'b0;
    chk("post_occ", Occupancy, 1);
    chk("post_data", MemWritebackDataOut, 16'h55);
    chk("post_addr", MemWritebackAddrOut, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_writeback_buffer.md
MEM_WRITEBACK_BUFFER -- requirements
Module: mem_writeback_buffer

Interface
REQ-001 Parameter DATABITWIDTH, default 16, SHALL set the writeback data width.
REQ-002 Parameter REGADDRBITWIDTH, default 4, SHALL set the destination register address width.
REQ-003 Parameter DEPTH, default 4, SHALL set the entry count; it SHALL be a power of two, at least 2.
REQ-004 Parameter DEPTHADDRWIDTH, default 2, SHALL equal log2(DEPTH).
REQ-005 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 async_rst_n  input  1  asynchronous active-low reset.
REQ-008 clk_en  input  1  global state-advance enable.
REQ-009 LoadValid  input  1  memory response carries a load result.
REQ-010 LoadReady  output  1  buffer can accept a load result.
REQ-011 LoadData  input  DATABITWIDTH  load result data.
REQ-012 LoadAddr  input  REGADDRBITWIDTH  destination register.
REQ-013 MemWritebackACK  output  1  entry pending toward the writeback arbiter.
REQ-014 MemWritebackREQ  input  1  arbiter grant for this port.
REQ-015 MemWritebackDataOut  output  DATABITWIDTH  head-entry data.
REQ-016 MemWritebackAddrOut  output  REGADDRBITWIDTH  head-entry register address.
REQ-017 Occupancy  output  DEPTHADDRWIDTH+1  current entry count, 0..DEPTH.
REQ-018 DropError  output  1  sticky flag: a load was offered while the buffer was full.

Function
REQ-019 The block SHALL be a circular FIFO of {LoadData, LoadAddr} entries with a write pointer, a read pointer, and a count register.
REQ-020 Push SHALL occur when LoadValid & LoadReady & clk_en; the entry is written at the write pointer and the write pointer increments modulo DEPTH.
REQ-021 Pop SHALL occur when MemWritebackACK & MemWritebackREQ & clk_en; the read pointer increments modulo DEPTH.
REQ-022 LoadReady SHALL equal (count != DEPTH), decoded from registered state only, with no combinational path from MemWritebackREQ.
REQ-023 MemWritebackACK SHALL equal (count != 0), decoded from registered state only.
REQ-024 MemWritebackDataOut/AddrOut SHALL present the entry at the read pointer when count != 0, and all-zeros when count == 0.
REQ-025 Latency: a load pushed at edge N SHALL raise MemWritebackACK after edge N if the buffer was empty (one cycle, no bypass).
REQ-026 Count update: push only -> +1; pop only -> -1; push and pop on the same edge -> unchanged, with both pointers advancing.
REQ-027 Full (count == DEPTH): LoadReady = 0 and no push occurs; LoadValid = 1 with clk_en = 1 SHALL set DropError on that edge.
REQ-028 Full with a same-cycle pop: the pop occurs, and LoadReady rises the following cycle.
REQ-029 Empty: MemWritebackREQ SHALL be ignored, with no pointer or count change.
REQ-030 MemWritebackREQ while MemWritebackACK = 0 SHALL never pop.
REQ-031 DropError, once set, SHALL hold until reset.
REQ-032 clk_en = 0 SHALL freeze pointers, count, storage, and DropError; outputs reflect the frozen state.
REQ-033 Occupancy SHALL equal the count register.
REQ-034 FIFO order SHALL be preserved: entries pop in push order, and a DEPTH-entry pointer wrap SHALL be invisible.

Reset
REQ-035 While async_rst_n = 0, pointers, count, and DropError SHALL be zero immediately, independent of clk; LoadReady = 1, MemWritebackACK = 0, outputs zero.
REQ-036 Reset asserted mid-operation SHALL discard all pending entries; no pop or push SHALL be recognised during reset.
REQ-037 Storage contents SHALL NOT require reset.
REQ-038 The first edge after deassertion SHALL be able to accept a push.

Verification
REQ-039 Single load (Data=0x1234, Addr=3), REQ held 1 -> ACK high one cycle after the push, DataOut=0x1234, AddrOut=3; pop on the next edge; Occupancy returns 0.
REQ-040 Four pushes (0xA0..0xA3) with REQ=0 -> Occupancy=4, LoadReady=0; a fifth LoadValid sets DropError=1; then REQ=1 pops 0xA0,0xA1,0xA2,0xA3 in order.
REQ-041 Full buffer, LoadValid=1 and REQ=1 same cycle -> pop only, Occupancy=3; the next cycle the push is accepted, Occupancy=4.
REQ-042 Continuous push and pop at Occupancy=2 for 10 cycles -> Occupancy stays 2, order preserved across pointer wrap.
REQ-043 clk_en=0 for 3 cycles with LoadValid=1 and REQ=1 -> no state change; async_rst_n pulsed low mid-stream -> ACK=0 and Occupancy=0 immediately, DropError cleared.
